nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of nibble entries in the output FIFO (power of two, ≥2).
REQ-002 The block SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, meaning synchronous active-high reset, sampled on the rising edge of CLK.
REQ-004 The block SHALL have port bit_in, input, 1, meaning serial data bit from the compressor.
REQ-005 The block SHALL have port bit_in_valid, input, 1, meaning bit_in carries a bit this cycle.
REQ-006 The block SHALL have port bit_in_ready, output, 1, meaning the packer can accept a bit this cycle.
REQ-007 The block SHALL have port flush_req, input, 1, meaning a level request to emit a partially filled nibble, held high until flush_ack.
REQ-008 The block SHALL have port flush_ack, output, 1, meaning a one-cycle pulse on the cycle a flush is performed.
REQ-009 The block SHALL have port nib_out, output, 4, meaning the nibble at the FIFO head.
REQ-010 The block SHALL have port nib_out_valid, output, 1, meaning nib_out is valid (FIFO not empty).
REQ-011 The block SHALL have port nib_out_ready, input, 1, meaning the downstream consumer takes nib_out this cycle.
REQ-012 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, meaning the number of nibbles currently stored.

Function
REQ-013 A bit SHALL be accepted when bit_in_valid && bit_in_ready; bit_in_ready SHALL equal (fifo_level < FIFO_DEPTH), combinational from registered state only.
REQ-014 Accepted bits SHALL fill the accumulator LSB first: the first bit goes to nibble bit 0, and the fourth bit goes to bit 3.
REQ-015 A 2-bit counter bit_cnt (0..3) SHALL advance on each accepted bit; on the acceptance that makes 4 bits, the completed nibble SHALL be pushed to the FIFO on that same edge and bit_cnt SHALL return to 0.
REQ-016 A flush SHALL be performed on a cycle when flush_req && bit_in_ready; flush_ack SHALL pulse high for exactly one cycle after that edge (registered).
REQ-017 On a flush with bit_cnt>0, the partial nibble SHALL be pushed with unfilled upper bits set to 0, and bit_cnt SHALL be cleared.
REQ-018 On a flush with bit_cnt==0 and no bit accepted, there SHALL be no push, but flush_ack SHALL still pulse.
REQ-019 When a bit is accepted and a flush is performed in the same cycle, the bit SHALL be included first; the resulting nibble (full or zero-padded) SHALL be pushed once, never twice.
REQ-020 While flush_req is high and bit_in_ready is low, the flush SHALL stay pending, with no flush_ack and no state change.
REQ-021 A pop SHALL occur when nib_out_valid && nib_out_ready; nib_out_valid SHALL equal (fifo_level != 0).
REQ-022 nib_out SHALL remain stable while nib_out_valid && !nib_out_ready.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged; a push SHALL never occur at full (guaranteed by REQ-013); a pop at empty SHALL be ignored.
REQ-024 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and nibble order SHALL be strictly preserved.
REQ-025 Output latency SHALL be one cycle: a nibble pushed on edge N is visible on nib_out with nib_out_valid=1 after edge N (when the FIFO was empty).
REQ-026 Throughput SHALL be one bit per cycle sustained while nib_out_ready=1, with no bubbles.

Reset
REQ-027 While Reset=1, the block SHALL drive on the next edge: bit_cnt=0, accumulator=0, FIFO pointers=0, fifo_level=0, nib_out_valid=0, nib_out=4'h0, and flush_ack=0.
REQ-028 Reset asserted mid-nibble or mid-flush SHALL discard all partial and stored data, with no nibble emitted afterward.
REQ-029 bit_in_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-030 The bench SHALL drive bits 1,0,1,1 on consecutive cycles with nib_out_ready=1 and check nib_out=4'hD, nib_out_valid=1, one cycle after the 4th bit.
REQ-031 The bench SHALL drive bits 1,1,0 then flush_req, and check nib_out=4'h3, a single flush_ack pulse, and bit_cnt=0 afterwards.
REQ-032 The bench SHALL drive the 4th bit and flush_req in the same cycle with bits 0,1,1,1, and check exactly one nibble 4'hE and one flush_ack.
REQ-033 The bench SHALL hold nib_out_ready=0 and stream 16 bits (FIFO_DEPTH=4), then check that bit_in_ready=0 after the 16th bit, fifo_level=4, and that a 17th bit is not accepted; it SHALL then release ready and check that the 4 nibbles drain in order and bit_in_ready returns to 1.
REQ-034 The bench SHALL assert flush_req with bit_cnt=0, and check flush_ack pulses with no change to fifo_level; it SHALL also assert flush_req while full, and check there is no flush_ack until a pop frees space.
REQ-035 The bench SHALL assert Reset after 2 bits with 3 nibbles stored, and check that all outputs are zero next cycle and that the next 4 bits 0,0,0,1 yield 4'h8.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: collects a serial bit stream LSB-first into nibbles and
// queues them in a small FIFO. A level-sensitive flush request emits a
// partially filled nibble (zero padded) and is acknowledged with a pulse.
module nibble_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          bit_in,
  input  logic                          bit_in_valid,
  output logic                          bit_in_ready,
  input  logic                          flush_req,
  output logic                          flush_ack,
  output logic [3:0]                    nib_out,
  output logic                          nib_out_valid,
  input  logic                          nib_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  // Accumulator state
  logic [1:0]    r_bit_cnt;
  logic [3:0]    r_acc;
  logic          r_flush_ack;

  // FIFO state
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Combinational handshake and datapath signals
  logic          w_bit_acc;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_fill;
  logic [3:0]    w_acc_next;

  // Space in the FIFO gates both new bits and flushes, so a push never
  // lands on a full FIFO.
  assign bit_in_ready  = (r_level < DEPTH_L);
  assign nib_out_valid = (r_level != '0);
  assign fifo_level    = r_level;
  assign flush_ack     = r_flush_ack;

  assign w_bit_acc = bit_in_valid && bit_in_ready;
  assign w_flush   = flush_req && bit_in_ready;
  assign w_pop     = nib_out_valid && nib_out_ready;

  // Number of bits held once this cycle's accepted bit (if any) is included
  assign w_fill = {1'b0, r_bit_cnt} + {2'b00, w_bit_acc};

  // Accumulator value with this cycle's bit merged in; bits above the fill
  // point are always zero, which gives the flush padding for free.
  always_comb begin
    w_acc_next = r_acc;
    if (w_bit_acc) begin
      w_acc_next[r_bit_cnt] = bit_in;
    end
  end

  // A completed nibble and a flush in the same cycle produce a single push.
  assign w_push = (w_bit_acc && (r_bit_cnt == 2'd3)) ||
                  (w_flush && (w_fill != 3'd0));

  // Bit accumulator and counter; cleared whenever a nibble leaves or a flush runs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_bit_cnt <= 2'd0;
      r_acc     <= 4'h0;
    end else if (w_push || w_flush) begin
      r_bit_cnt <= 2'd0;
      r_acc     <= 4'h0;
    end else if (w_bit_acc) begin
      r_bit_cnt <= r_bit_cnt + 2'd1;
      r_acc     <= w_acc_next;
    end
  end

  // Registered one-cycle acknowledge for each performed flush
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_flush_ack <= 1'b0;
    end else begin
      r_flush_ack <= w_flush;
    end
  end

  // FIFO storage; contents need no reset because the output is gated by level
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_acc_next;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Head of FIFO, forced to zero when nothing is stored
  assign nib_out = nib_out_valid ? r_mem[r_rd_ptr] : 4'h0;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: a scoreboard queue holds expected
// nibbles, a negedge monitor pops and compares on every output handshake.
module tb_nibble_packer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_in_valid = 1'b0;
  logic       bit_in_ready;
  logic       flush_req = 1'b0;
  logic       flush_ack;
  logic [3:0] nib_out;
  logic       nib_out_valid;
  logic       nib_out_ready = 1'b1;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [3:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [3:0] prev_nib = 4'h0;

  nibble_packer #(.FIFO_DEPTH(4)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .bit_in        (bit_in),
    .bit_in_valid  (bit_in_valid),
    .bit_in_ready  (bit_in_ready),
    .flush_req     (flush_req),
    .flush_ack     (flush_ack),
    .nib_out       (nib_out),
    .nib_out_valid (nib_out_valid),
    .nib_out_ready (nib_out_ready),
    .fifo_level    (fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_in_valid = 1'b1;
    tick();
    bit_in_valid = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    exp_q.push_back(n);
    for (int i = 0; i < 4; i++) send_bit(n[i]);
  endtask

  // Monitor: scoreboard compare on each pop, hold-stability, flush_ack count
  always @(negedge CLK) begin
    if (Reset === 1'b0) begin
      if (flush_ack === 1'b1) ack_cnt++;
      if (prev_hold && nib_out_valid) chk("hold_stable", nib_out, prev_nib);
      if (nib_out_valid && nib_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %0h, expected no nibble", nib_out);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          $display("pop nib=%0h expected=%0h", nib_out, e);
          chk("scoreboard_nib", nib_out, e);
        end
      end
      prev_hold = nib_out_valid && !nib_out_ready;
      prev_nib  = nib_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    logic seen;

    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_valid", nib_out_valid, 0);
    chk("rst_nib", nib_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ack", flush_ack, 0);
    chk("rst_bit_ready", bit_in_ready, 1);

    // Bits 1,0,1,1 -> 4'hD one cycle after the fourth bit
    nib_out_ready = 1'b1;
    exp_q.push_back(4'hD);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("d_nib", nib_out, 4'hD);
    chk("d_valid", nib_out_valid, 1);
    tick();

    // Bits 1,1,0 then flush -> 4'h3, single ack, counter cleared
    a0 = ack_cnt;
    exp_q.push_back(4'h3);
    send_bit(1); send_bit(1); send_bit(0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("f3_ack", flush_ack, 1);
    chk("f3_nib", nib_out, 4'h3);
    tick();
    chk("f3_ack_low", flush_ack, 0);
    chk("f3_ack_count", ack_cnt - a0, 1);
    exp_q.push_back(4'h1);
    send_bit(1); send_bit(0); send_bit(0); send_bit(0);
    tick();

    // Fourth bit and flush together with bits 0,1,1,1 -> one 4'hE, one ack
    a0 = ack_cnt;
    exp_q.push_back(4'hE);
    send_bit(0); send_bit(1); send_bit(1);
    bit_in = 1'b1;
    bit_in_valid = 1'b1;
    flush_req = 1'b1;
    tick();
    bit_in_valid = 1'b0;
    flush_req = 1'b0;
    chk("e_nib", nib_out, 4'hE);
    chk("e_level", fifo_level, 1);
    tick();
    tick();
    chk("e_ack_count", ack_cnt - a0, 1);
    chk("e_level_after", fifo_level, 0);

    // Fill the FIFO with ready low, 17th bit refused, flush pends while full
    nib_out_ready = 1'b0;
    send_nib(4'hA); send_nib(4'h5); send_nib(4'hC); send_nib(4'h3);
    chk("full_bit_ready", bit_in_ready, 0);
    chk("full_level", fifo_level, 4);
    bit_in = 1'b1;
    bit_in_valid = 1'b1;
    tick();
    tick();
    bit_in_valid = 1'b0;
    chk("full_level_17", fifo_level, 4);
    a0 = ack_cnt;
    flush_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_flush_pending", flush_ack, 0);
    end
    nib_out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = flush_ack;
    end
    chk("full_flush_after_pop", seen, 1);
    flush_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = (fifo_level == 3'd0);
    end
    chk("drain_level", fifo_level, 0);
    chk("drain_bit_ready", bit_in_ready, 1);
    chk("full_ack_count", ack_cnt - a0, 1);
    send_nib(4'h6);
    tick();

    // Empty flush (bit_cnt == 0) leaves level unchanged
    nib_out_ready = 1'b0;
    send_nib(4'h9);
    a0 = ack_cnt;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("ef_ack", flush_ack, 1);
    chk("ef_level", fifo_level, 1);
    tick();
    chk("ef_ack_low", flush_ack, 0);
    chk("ef_level2", fifo_level, 1);
    chk("ef_ack_count", ack_cnt - a0, 1);
    nib_out_ready = 1'b1;
    tick();
    tick();

    // Reset with 3 nibbles stored, 2 partial bits and a flush pending
    nib_out_ready = 1'b0;
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h4);
    send_bit(1); send_bit(1);
    chk("pre_rst_level", fifo_level, 3);
    Reset = 1'b1;
    flush_req = 1'b1;
    tick();
    Reset = 1'b0;
    flush_req = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", nib_out_valid, 0);
    chk("mid_rst_nib", nib_out, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ack", flush_ack, 0);
    chk("mid_rst_bit_ready", bit_in_ready, 1);
    nib_out_ready = 1'b1;
    exp_q.push_back(4'h8);
    send_bit(0); send_bit(0); send_bit(0); send_bit(1);
    chk("post_rst_nib", nib_out, 4'h8);
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("final_level", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
